// File: rtl/matmul_stream_ctrl.sv
// Stream front/back end for the matmul engine: loads A then B, kicks matmul, drains C.
// Optional MATMUL_STREAM_TLAST_EN adds in_last, out_last and err_framing.
module matmul_stream_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int MATRIX_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef MATMUL_STREAM_TLAST_EN
  input  logic                  in_last,
  output logic                  out_last,
  output logic                  err_framing,
`endif
  output logic [DATA_WIDTH-1:0] a_din,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] b_din,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_wr_en,
  output logic                  mm_start,
  input  logic                  mm_done,
  input  logic [DATA_WIDTH-1:0] c_dout,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] NN = CW'(MATRIX_SIZE * MATRIX_SIZE);
  localparam logic [CW-1:0] LAST = NN - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [1:0] occ_q, occ_d;
  logic inflight_q, inflight_d;
  logic wp_q, wp_d, rp_q, rp_d;
  logic done_prev_q, done_prev_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic hs, load_last, pop, drain_last, rise, issue;
  logic [2:0] room;

  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = fifo_q[rp_q];
  assign pop        = out_valid && out_ready;
  assign hs         = in_valid && in_ready;
  assign load_last  = hs && (cnt_q == LAST);
  assign drain_last = pop && (out_cnt_q == LAST);
  // A done level left high by the previous run is not an edge.
  assign rise       = mm_done && !done_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid)   state_d = S_LOAD_A;
      S_LOAD_A: if (load_last)  state_d = S_LOAD_B;
      S_LOAD_B: if (load_last)  state_d = S_START;
      S_START:                  state_d = S_WAIT;
      S_WAIT:   if (rise)       state_d = S_DRAIN;
      S_DRAIN:  if (drain_last) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    mm_start = (state_q == S_START);
    busy     = (state_q != S_IDLE);
    a_wr_en  = (state_q == S_LOAD_A) && in_valid;
    b_wr_en  = (state_q == S_LOAD_B) && in_valid;
    a_addr   = a_wr_en ? cnt_q[ADDR_WIDTH-1:0] : '0;
    a_din    = a_wr_en ? in_data : '0;
    b_addr   = b_wr_en ? cnt_q[ADDR_WIDTH-1:0] : '0;
    b_din    = b_wr_en ? in_data : '0;
    room     = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    issue    = (state_q == S_DRAIN) && (rd_idx_q < NN) && (room < 3'd2);
    c_addr   = issue ? rd_idx_q[ADDR_WIDTH-1:0] : '0;
  end

  always_comb begin
    cnt_d       = cnt_q;
    rd_idx_d    = rd_idx_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = issue;
    occ_d       = occ_q + 2'(inflight_q) - 2'(pop);
    wp_d        = wp_q ^ inflight_q;
    rp_d        = rp_q ^ pop;
    done_prev_d = mm_done;
    fifo_d      = fifo_q;
    if (inflight_q) fifo_d[wp_q] = c_dout;
    if (hs)    cnt_d     = load_last ? '0 : cnt_q + 1'b1;
    if (issue) rd_idx_d  = rd_idx_q + 1'b1;
    if (pop)   out_cnt_d = out_cnt_q + 1'b1;
    if (drain_last) begin
      rd_idx_d  = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      out_cnt_q   <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      done_prev_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      out_cnt_q   <= out_cnt_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      done_prev_q <= done_prev_d;
      fifo_q      <= fifo_d;
    end
  end

`ifdef MATMUL_STREAM_TLAST_EN
  logic err_q, err_d;

  assign out_last    = out_valid && (out_cnt_q == LAST);
  assign err_framing = err_q;

  always_comb begin
    err_d = err_q;
    if (hs && in_last && ((state_q == S_LOAD_A) || (cnt_q != LAST)))
      err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

endmodule
